pl_rv32_fetch_unit: RTL and testbench
=====================================

// Module: pl_rv32_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the RV32 pipeline; sits directly upstream of the decode/controller stage.
//  - Owns the PC.
//  - Issues in-order word requests to instruction memory.
//  - Buffers returned words in a small FIFO and presents {instr, pc, fault} to decode over valid/ready.
//  - Redirects from execute (branch/jump) flush buffered words and discard stale in-flight responses.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2); also the max requests in flight
// PORTS
//  clk             in   1   clock, all logic on rising edge
//  rst             in   1   synchronous reset, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word-aligned fetch address
//  imem_rsp_valid  in   1   response valid; responses are in order, latency >=1 cycle, no backpressure
//  imem_rsp_data   in   32  instruction word
//  imem_rsp_err    in   1   bus/access error for this response
//  redirect_valid  in   1   execute redirects fetch (taken branch/jump)
//  redirect_pc     in   32  new fetch target
//  if_valid        out  1   decode entry valid (FIFO non-empty)
//  if_ready        in   1   decode accepts entry (low = decode stall)
//  if_instr        out  32  instruction word at FIFO head
//  if_pc           out  32  PC of if_instr
//  if_fault        out  1   entry carries fetch fault (bus error or misaligned target); if_instr = 0
// BEHAVIOUR
//  Reset: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_fault=0.
//  Reset also clears: FIFO, outstanding count, drop count; state=RUN.
//  - First request is asserted the cycle after rst deasserts; rst mid-operation discards everything the same way.
//  Credits:
//  - imem_req_valid=1 only when state=RUN, no redirect this cycle, and (outstanding + fifo_count) < FIFO_DEPTH.
//  - Responses therefore can never overflow the FIFO.
//  Request handshake:
//  - Transfer occurs when valid&ready; pc <= pc+4 and outstanding++ on that edge.
//  - While valid & !ready, addr is held stable.
//  - Only a redirect may retract a pending request.
//  Response: on imem_rsp_valid, if drop_cnt>0, drop_cnt-- and the word is discarded; otherwise push {data,pc_of_req,err}.
//  - Per-request PC is tracked in a FIFO_DEPTH-entry address queue, or recomputed from a head-PC counter.
//  - outstanding-- on every response.
//  Latency: request accepted at cycle T, response at T+L -> if_valid at T+L+1 (registered; no bypass).
//  Decode handshake: pop on if_valid & if_ready; if_* are stable while if_valid & !if_ready.
//  Redirect (highest priority):
//  - FIFO flushed; drop_cnt <= outstanding (minus any response arriving that same cycle, which is itself dropped).
//  - No request is issued that cycle; pc <= redirect_pc; state <= RUN.
//  - A same-cycle decode pop completes first; the entry is consumed, not replayed.
//  - A response arriving the same cycle as the redirect is discarded.
//  - redirect_pc[1:0] != 0: no memory request; the cycle after, push one entry {instr=0, pc=redirect_pc, fault=1}; state <= HALT.
//  FSM:
//  - RUN: issue per credits.
//  - HALT: no requests; FIFO and in-flight responses still drain normally. Only redirect leaves HALT (-> RUN).
//  - Entry to HALT: a pushed response with imem_rsp_err=1 pushes a fault entry and sets HALT on the same edge; requests already in flight are dropped (drop_cnt <= remaining outstanding).
//  Widths: pc wraps mod 2^32 (32'hFFFF_FFFC + 4 = 0), no error. Counters are $clog2(FIFO_DEPTH+1) bits; drop_cnt <= outstanding always.
// TESTING
//  1 Reset, req_ready=1, 1-cycle memory, if_ready=1 -> addrs 0,4,8,...; if_valid from cycle 3; if_pc 0,4,8 in order.
//  2 Hold if_ready=0 -> exactly FIFO_DEPTH words buffered, req_valid drops; release -> no word lost/duplicated.
//  3 Latency-3 memory, 2 in flight, redirect_pc=0x100 -> both stale rsps dropped; next if_pc=0x100.
//  4 Redirect same cycle as rsp_valid and if_valid&if_ready -> popped entry consumed once; rsp dropped; refetch from target.
//  5 rsp_err=1 on PC 0x8 -> entry {pc=8, fault=1, instr=0}; no further requests until redirect; redirect resumes.
//  6 redirect_pc=0x102 -> no imem request; one fault entry pc=0x102; HALT. Also cover PC wrap at 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/pl_rv32_fetch_unit.sv
// rtl/pl_rv32_fetch_unit.sv - RV32 fetch stage: PC, credited imem requests, decode buffer, redirect flush
module pl_rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_fault
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic          misalign_q, misalign_d;
    logic [31:0]   buf_instr_q [FIFO_DEPTH];
    logic [31:0]   buf_instr_d [FIFO_DEPTH];
    logic [31:0]   buf_pc_q    [FIFO_DEPTH];
    logic [31:0]   buf_pc_d    [FIFO_DEPTH];
    logic          buf_fault_q [FIFO_DEPTH];
    logic          buf_fault_d [FIFO_DEPTH];

    logic          credit_ok;
    logic          req_fire;
    logic          pop;
    logic          push;
    logic [31:0]   push_instr;
    logic [31:0]   push_pc;
    logic          push_fault;

    // Buffered plus in-flight words never exceed the buffer, so responses need no backpressure.
    assign credit_ok      = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C;
    assign imem_req_valid = !rst && (state_q == ST_RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid = (cnt_q != '0);
    assign pop      = if_valid && if_ready;
    assign if_instr = if_valid ? buf_instr_q[rd_q] : '0;
    assign if_pc    = if_valid ? buf_pc_q[rd_q]    : '0;
    assign if_fault = if_valid && buf_fault_q[rd_q];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rsp_pc_d    = rsp_pc_q;
        drop_d      = drop_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        misalign_d  = misalign_q;
        out_d       = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
        push        = 1'b0;
        push_instr  = '0;
        push_pc     = '0;
        push_fault  = 1'b0;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_fault_d = buf_fault_q;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end

        if (redirect_valid) begin
            // A response landing this cycle is already counted out of out_d and is discarded here.
            pc_d       = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = out_d;
            misalign_d = (redirect_pc[1:0] != 2'b00);
            state_d    = misalign_d ? ST_HALT : ST_RUN;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end else if (imem_rsp_valid && !misalign_q) begin
                push       = 1'b1;
                push_instr = imem_rsp_err ? 32'd0 : imem_rsp_data;
                push_pc    = rsp_pc_q;
                push_fault = imem_rsp_err;
                rsp_pc_d   = rsp_pc_q + 32'd4;
                if (imem_rsp_err) begin
                    state_d = ST_HALT;
                    drop_d  = out_d;
                end
            end
            if (misalign_q) begin
                push       = 1'b1;
                push_instr = '0;
                push_pc    = rsp_pc_q;
                push_fault = 1'b1;
                misalign_d = 1'b0;
            end
        end

        if (push) begin
            buf_instr_d[wr_q] = push_instr;
            buf_pc_d[wr_q]    = push_pc;
            buf_fault_d[wr_q] = push_fault;
            wr_d              = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);

        if (redirect_valid) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_instr_q <= buf_instr_d;
        buf_pc_q    <= buf_pc_d;
        buf_fault_q <= buf_fault_d;
    end
endmodule

// File: tb/tb_pl_rv32_fetch_unit.sv
// tb/tb_pl_rv32_fetch_unit.sv - self-checking bench for pl_rv32_fetch_unit
module tb_pl_rv32_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_fault;

    always #5 clk = ~clk;

    pl_rv32_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc), .if_fault(if_fault)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        bit          rst_in;
        bit          exp_rv;
        logic [31:0] exp_addr;
        bit          exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       memq[$];
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          last_due = 0;
    int          epoch = 0;
    logic [31:0] exp_pc = RPC;
    logic [31:0] exp_req_pc = RPC;
    bit          halted = 0;
    bit          exp_done = 0;
    logic [31:0] err_pc = 32'h1;
    bit          err_en = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    bit          s_req_valid, s_if_valid, s_if_fault, s_pop, s_fire;
    logic [31:0] s_req_addr, s_if_pc, s_if_instr;

    function automatic logic [31:0] m_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit is_err(input logic [31:0] a);
        return (a == err_pc) || (err_en && ((int'(a[9:2]) % 23) == 7));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        bit ef;
        ef = (exp_pc[1:0] != 2'b00) || is_err(exp_pc);
        if (exp_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pop_after_fault: got entry pc %h, expected no entry", s_if_pc);
        end else begin
            chk("if_pc", s_if_pc, exp_pc);
            chk("if_fault", 32'(s_if_fault), 32'(ef));
            chk("if_instr", s_if_instr, ef ? 32'd0 : m_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            if (ef) exp_done = 1;
        end
    endtask

    // One clock: drive memory response, sample at the falling edge, advance the reference model.
    task automatic step();
        mreq_t m;
        bit    rsp_cur;
        int    due;
        rsp_cur = 0;
        if (!rst && memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m_word(m.addr);
            imem_rsp_err   = is_err(m.addr);
            rsp_cur        = (m.epoch == epoch);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            imem_rsp_err   = 1'b0;
        end
        #4;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_if_valid  = if_valid;
        s_if_pc     = if_pc;
        s_if_instr  = if_instr;
        s_if_fault  = if_fault;
        s_fire      = s_req_valid && imem_req_ready;
        s_pop       = s_if_valid && if_ready;
        if (rst) begin
            memq.delete();
            epoch++;
            exp_pc     = RPC;
            exp_req_pc = RPC;
            halted     = 0;
            exp_done   = 0;
            last_due   = 0;
        end else begin
            if (redirect_valid) chk("req_on_redirect", 32'(s_req_valid), 32'd0);
            else if (halted) chk("req_while_halted", 32'(s_req_valid), 32'd0);
            if (s_pop) check_pop();
            if (imem_rsp_valid && rsp_cur && !redirect_valid && imem_rsp_err) begin
                halted = 1;
                epoch++;
            end
            if (s_fire) begin
                chk("req_addr", s_req_addr, exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                memq.push_back('{addr: s_req_addr, due: due, epoch: epoch});
            end
            if (redirect_valid) begin
                epoch++;
                exp_pc     = redirect_pc;
                exp_req_pc = redirect_pc;
                halted     = (redirect_pc[1:0] != 2'b00);
                exp_done   = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic redir(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pop(input int bound, input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_pop && k < bound);
        if (!s_pop) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no decode entry, expected one within %0d cycles", name, bound);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   burst, nfire, npop, r;
        bit   found;

        vecs[0] = '{1, 0, RPC,      0, 32'h0};
        vecs[1] = '{0, 1, 32'h0,    0, 32'h0};
        vecs[2] = '{0, 1, 32'h4,    0, 32'h0};
        vecs[3] = '{0, 0, 32'h8,    1, 32'h0};
        vecs[4] = '{0, 1, 32'h8,    1, 32'h4};
        vecs[5] = '{0, 1, 32'hC,    0, 32'h0};
        vecs[6] = '{0, 0, 32'h10,   1, 32'h8};
        vecs[7] = '{0, 1, 32'h10,   1, 32'hC};
        vecs[8] = '{0, 1, 32'h14,   0, 32'h0};
        vecs[9] = '{0, 0, 32'h18,   1, 32'h10};

        @(posedge clk);
        #1;
        step();
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst_in;
            step();
            chk($sformatf("t1_req_valid[%0d]", i), 32'(s_req_valid), 32'(vecs[i].exp_rv));
            chk($sformatf("t1_req_addr[%0d]", i), s_req_addr, vecs[i].exp_addr);
            chk($sformatf("t1_if_valid[%0d]", i), 32'(s_if_valid), 32'(vecs[i].exp_iv));
            chk($sformatf("t1_if_pc[%0d]", i), s_if_pc, vecs[i].exp_pc);
            chk($sformatf("t1_if_instr[%0d]", i), s_if_instr, vecs[i].exp_iv ? m_word(vecs[i].exp_pc) : 32'd0);
        end

        if_ready = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("t2_req_valid_full", 32'(s_req_valid), 32'd0);
        chk("t2_if_valid_full", 32'(s_if_valid), 32'd1);
        chk("t2_inflight", 32'(memq.size()), 32'd0);
        if_ready = 1'b1;
        burst = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (s_pop) burst++;
            else break;
        end
        chk("t2_burst", 32'(burst), 32'(DEPTH));

        lat_min = 3;
        lat_max = 3;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (memq.size() == 2 && memq[0].due > cyc) begin
                found = 1;
                redir(32'h100);
            end else begin
                step();
            end
        end
        chk("t3_two_in_flight", 32'(found), 32'd1);
        wait_pop(20, "t3_wait");
        chk("t3_target_pc", s_if_pc, 32'h100);

        lat_min = 1;
        lat_max = 1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (if_valid && if_ready && memq.size() > 0 && memq[0].due <= cyc) begin
                found = 1;
                redir(32'h200);
            end else begin
                step();
            end
        end
        chk("t4_collision", 32'(found), 32'd1);
        wait_pop(20, "t4_wait");
        chk("t4_target_pc", s_if_pc, 32'h200);

        err_pc = 32'h8;
        redir(32'h0);
        wait_pop(20, "t5_pop0");
        chk("t5_pc0", s_if_pc, 32'h0);
        wait_pop(20, "t5_pop1");
        chk("t5_pc1", s_if_pc, 32'h4);
        wait_pop(20, "t5_pop2");
        chk("t5_fault_pc", s_if_pc, 32'h8);
        chk("t5_fault_flag", 32'(s_if_fault), 32'd1);
        chk("t5_fault_instr", s_if_instr, 32'd0);
        nfire = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_fire) nfire++;
        end
        chk("t5_halt_no_req", 32'(nfire), 32'd0);
        redir(32'h40);
        err_pc = 32'h1;
        wait_pop(20, "t5_resume");
        chk("t5_resume_pc", s_if_pc, 32'h40);

        redir(32'h102);
        nfire = 0;
        npop = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_fire) nfire++;
            if (s_pop) begin
                npop++;
                chk("t6_fault_pc", s_if_pc, 32'h102);
                chk("t6_fault_flag", 32'(s_if_fault), 32'd1);
            end
        end
        chk("t6_no_req", 32'(nfire), 32'd0);
        chk("t6_one_entry", 32'(npop), 32'd1);
        redir(32'hFFFF_FFF8);
        for (int k = 0; k < 4; k++) wait_pop(20, "t6_wrap_wait");
        chk("t6_wrap_pc", s_if_pc, 32'h4);

        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        step();
        step();
        chk("rst_req_valid", 32'(s_req_valid), 32'd0);
        chk("rst_req_addr", s_req_addr, RPC);
        chk("rst_if_valid", 32'(s_if_valid), 32'd0);
        chk("rst_if_pc", s_if_pc, 32'd0);
        chk("rst_if_instr", s_if_instr, 32'd0);
        chk("rst_if_fault", 32'(s_if_fault), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_first_req", 32'(s_req_valid), 32'd1);
        chk("rst_first_addr", s_req_addr, RPC);

        err_en  = 1;
        lat_min = 1;
        lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if_ready       = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < ((halted || exp_done) ? 15 : 3)) begin
                r = $urandom_range(0, 9);
                redirect_valid = 1'b1;
                if (r == 0)      redirect_pc = {22'h0, 8'($urandom), 2'($urandom_range(1, 3))};
                else if (r == 1) redirect_pc = 32'hFFFF_FFF0;
                else             redirect_pc = {22'h0, 8'($urandom), 2'b00};
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
